// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module seq_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [2:0]      MDU_op_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] numerator_i,
    input  logic [XLEN-1:0] denominator_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            done_o,
    output logic            busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(XLEN);

    logic [1:0]      state;
    logic [CW-1:0]   counter;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dabs;
    logic            q_neg;
    logic            r_neg;

    logic            is_signed;
    logic            n_neg;
    logic            d_neg;
    logic [XLEN-1:0] n_abs;
    logic [XLEN-1:0] d_abs;
    logic            div_zero;
    logic            ovf;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] trial;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] q_nxt;
    logic            last;
    logic            unused_op;

    // Quotient and remainder are always both produced, so funct3[1] has no effect.
    assign unused_op = MDU_op_i[1];

    assign is_signed = ~MDU_op_i[0];
    assign n_neg     = is_signed & numerator_i[XLEN-1];
    assign d_neg     = is_signed & denominator_i[XLEN-1];
    assign n_abs     = n_neg ? -numerator_i : numerator_i;
    assign d_abs     = d_neg ? -denominator_i : denominator_i;
    assign div_zero  = (denominator_i == '0);
    assign ovf       = is_signed && (numerator_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (denominator_i == '1);

    // The partial remainder stays below |D|, so the low XLEN bits of the subtraction suffice.
    assign shifted = {rem, dvd[XLEN-1]};
    assign ge      = (shifted >= {1'b0, dabs});
    assign trial   = shifted[XLEN-1:0] - dabs;
    assign rem_nxt = ge ? trial : shifted[XLEN-1:0];
    assign q_nxt   = {dvd[XLEN-2:0], ge};
    assign last    = (counter == CW'(XLEN-1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            counter     <= '0;
            dvd         <= '0;
            rem         <= '0;
            dabs        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && MDU_op_i[2]) begin
                        q_neg   <= n_neg ^ d_neg;
                        r_neg   <= n_neg;
                        dabs    <= d_abs;
                        dvd     <= n_abs;
                        rem     <= '0;
                        counter <= '0;
                        if (div_zero) begin
                            quotient_o  <= '1;
                            remainder_o <= numerator_i;
                            state       <= S_DONE;
                        end else if (ovf) begin
                            quotient_o  <= numerator_i;
                            remainder_o <= '0;
                            state       <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!start_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem     <= rem_nxt;
                        dvd     <= q_nxt;
                        counter <= counter + CW'(1);
                        if (last) begin
                            quotient_o  <= q_neg ? -q_nxt : q_nxt;
                            remainder_o <= r_neg ? -rem_nxt : rem_nxt;
                            state       <= S_DONE;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider
module tb_seq_divider;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  MDU_op_i;
    logic        start_i;
    logic [31:0] numerator_i;
    logic [31:0] denominator_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        done_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    seq_divider #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .MDU_op_i(MDU_op_i), .start_i(start_i),
        .numerator_i(numerator_i), .denominator_i(denominator_i),
        .quotient_o(quotient_o), .remainder_o(remainder_o),
        .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] n,
                                          input logic [31:0] d);
        int sn;
        int sd;
        int sq;
        int sr;
        if (d == 32'd0) return {32'hFFFF_FFFF, n};
        if (op[0]) return {n / d, n % d};
        if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        sn = n;
        sd = d;
        sq = sn / sd;
        sr = sn % sd;
        return {sq, sr};
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] n,
                                       input logic [31:0] d);
        if (d == 32'd0) return 1;
        if (!op[0] && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!done_o && n < 100);
    endtask

    // Issue one operation starting in the current cycle, check latency and results,
    // then drop start and confirm the done pulse lasted one cycle.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] n,
                         input logic [31:0] d);
        int lat;
        logic [63:0] e;
        e = model(op, n, d);
        MDU_op_i      = op;
        numerator_i   = n;
        denominator_i = d;
        start_i       = 1'b1;
        wait_done(lat);
        check({tag, "_lat"}, lat, exp_latency(op, n, d));
        check({tag, "_q"}, quotient_o, e[63:32]);
        check({tag, "_r"}, remainder_o, e[31:0]);
        start_i = 1'b0;
        cyc();
        check({tag, "_done_low"}, {31'd0, done_o}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            4: return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int pulses;
        rst_i = 1'b0;
        start_i = 1'b0;
        MDU_op_i = 3'b101;
        numerator_i = '0;
        denominator_i = '0;
        repeat (3) cyc();
        check("rst_q", quotient_o, 32'h0);
        check("rst_r", remainder_o, 32'h0);
        check("rst_flags", {30'd0, done_o, busy_o}, 32'd0);
        rst_i = 1'b1;
        cyc();

        do_op("divu_100_7", 3'b101, 32'd100, 32'd7);
        do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE);
        do_op("divu_by0", 3'b101, 32'h1234, 32'd0);
        do_op("div_by0", 3'b100, 32'hFFFF_FFF0, 32'd0);
        do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF);

        // Back-to-back with start held through the done cycle.
        MDU_op_i = 3'b101;
        numerator_i = 32'hFFFF_FFFF;
        denominator_i = 32'd1;
        start_i = 1'b1;
        wait_done(lat);
        check("b2b_lat1", lat, 33);
        check("b2b_q1", quotient_o, 32'hFFFF_FFFF);
        check("b2b_r1", remainder_o, 32'h0);
        cyc();
        check("b2b_done_gap", {31'd0, done_o}, 32'd0);
        numerator_i = 32'd10;
        denominator_i = 32'd3;
        wait_done(lat);
        check("b2b_lat2", lat, 33);
        check("b2b_q2", quotient_o, 32'd3);
        check("b2b_r2", remainder_o, 32'd1);
        start_i = 1'b0;
        cyc();

        // Abort mid-operation: outputs keep 3 r 1.
        numerator_i = 32'd50;
        denominator_i = 32'd5;
        start_i = 1'b1;
        repeat (10) cyc();
        start_i = 1'b0;
        cyc();
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) pulses++;
            cyc();
        end
        check("abort_no_done", pulses, 0);
        check("abort_q_hold", quotient_o, 32'd3);
        check("abort_r_hold", remainder_o, 32'd1);
        do_op("div_50_5", 3'b100, 32'd50, 32'd5);

        // Reset in cycle 5 of an operation.
        MDU_op_i = 3'b101;
        numerator_i = 32'd100;
        denominator_i = 32'd7;
        start_i = 1'b1;
        repeat (5) cyc();
        rst_i = 1'b0;
        cyc();
        check("mid_rst_flags", {30'd0, done_o, busy_o}, 32'd0);
        check("mid_rst_q", quotient_o, 32'h0);
        check("mid_rst_r", remainder_o, 32'h0);
        rst_i = 1'b1;
        start_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done_o) pulses++;
        end
        check("mid_rst_no_done", pulses, 0);

        // A start with funct3[2]=0 is not a divide and must be ignored.
        MDU_op_i = 3'b001;
        start_i = 1'b1;
        cyc();
        check("non_div_ignored", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0;
        cyc();

        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rand%0d", i), {1'b1, 2'($urandom_range(0, 3))}, pick(), pick());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
